// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out tags at issue, captures CDB results,
// forwards operands to issue and retires in program order, flushing all
// speculative state when a mispredicted branch reaches the head.

// One ROB slot. Clear beats allocate, and allocate beats a CDB write.
module rob_entry #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              alloc,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic              alloc_wen,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_mis,
  output logic              valid,
  output logic              done,
  output logic              mis,
  output logic              wen,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] data
);

  // Slot state: clear on retire/flush, load on allocate, complete on CDB hit
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      done  <= 1'b0;
      mis   <= 1'b0;
      wen   <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      done  <= 1'b0;
      mis   <= 1'b0;
      wen   <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (alloc) begin
      valid <= 1'b1;
      done  <= 1'b0;
      mis   <= 1'b0;
      wen   <= alloc_wen;
      rd    <= alloc_rd;
      data  <= '0;
    end else if (wr && valid) begin
      done  <= 1'b1;
      data  <= wr_data;
      mis   <= wr_mis;
    end
  end

endmodule

module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic              alloc_wen,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  input  logic [TAG_W-1:0]  src_tag,
  output logic              src_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_rd,
  output logic              commit_wen,
  output logic [DATA_W-1:0] commit_data,
  output logic              flush,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]              ent_valid, ent_done, ent_mis, ent_wen;
  logic [DEPTH-1:0][REG_W-1:0]   ent_rd;
  logic [DEPTH-1:0][DATA_W-1:0]  ent_data;

  logic [TAG_W-1:0] head, tail;
  logic             commit_fire, head_flush, alloc_fire;

  // Head retires once its result is in; a mispredicted head also flushes.
  // A full buffer never takes an allocation, even while the head retires.
  always_comb begin
    commit_fire = ent_valid[head] && ent_done[head];
    head_flush  = commit_fire && ent_mis[head];
    alloc_ready = (count != FULL_CNT) && !head_flush;
    alloc_fire  = alloc_valid && alloc_ready;
    alloc_tag   = tail;
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      rob_entry #(.DATA_W(DATA_W), .REG_W(REG_W)) u_ent (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .clr       (head_flush || (commit_fire && (head == TAG_W'(i)))),
        .alloc     (alloc_fire && (tail == TAG_W'(i))),
        .alloc_rd  (alloc_rd),
        .alloc_wen (alloc_wen),
        .wr        (cdb_valid && (cdb_tag == TAG_W'(i))),
        .wr_data   (cdb_data),
        .wr_mis    (cdb_mispredict),
        .valid     (ent_valid[i]),
        .done      (ent_done[i]),
        .mis       (ent_mis[i]),
        .wen       (ent_wen[i]),
        .rd        (ent_rd[i]),
        .data      (ent_data[i])
      );
    end
  endgenerate

  // Operand lookup with same-cycle CDB bypass; invalid slots read as zero
  always_comb begin
    src_ready = 1'b0;
    src_data  = '0;
    if (ent_valid[src_tag]) begin
      if (cdb_valid && (cdb_tag == src_tag)) begin
        src_ready = 1'b1;
        src_data  = cdb_data;
      end else begin
        src_ready = ent_done[src_tag];
        src_data  = ent_data[src_tag];
      end
    end
  end

  // Pointers and occupancy; a flush rewinds everything to empty
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (head_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (commit_fire) head <= head + TAG_W'(1);
      if (alloc_fire)  tail <= tail + TAG_W'(1);
      if (alloc_fire && !commit_fire)      count <= count + (TAG_W+1)'(1);
      else if (!alloc_fire && commit_fire) count <= count - (TAG_W+1)'(1);
    end
  end

  // Registered retire port; payload holds between commits
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_wen   <= 1'b0;
      commit_data  <= '0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= commit_fire;
      flush        <= head_flush;
      if (commit_fire) begin
        commit_rd   <= ent_rd[head];
        commit_wen  <= ent_wen[head];
        commit_data <= ent_data[head];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed table, hand sequences for full/bypass/
// mispredict/reset corners, and random traffic against a queue-based model.
module tb_reorder_buffer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int TAG_W  = 3;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              alloc_valid = 1'b0;
  logic [REG_W-1:0]  alloc_rd = '0;
  logic              alloc_wen = 1'b0;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_data = '0;
  logic              cdb_mispredict = 1'b0;
  logic [TAG_W-1:0]  src_tag = '0;
  logic              src_ready;
  logic [DATA_W-1:0] src_data;
  logic              commit_valid;
  logic [REG_W-1:0]  commit_rd;
  logic              commit_wen;
  logic [DATA_W-1:0] commit_data;
  logic              flush;
  logic [TAG_W:0]    count;

  reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .TAG_W(TAG_W)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_wen(alloc_wen),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict),
    .src_tag(src_tag), .src_ready(src_ready), .src_data(src_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_wen(commit_wen),
    .commit_data(commit_data), .flush(flush), .count(count)
  );

  always #5 clk1 = ~clk1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: program-ordered queue ----------------
  typedef struct {
    int          tag;
    logic [3:0]  rd;
    logic        wen;
    logic        done;
    logic        mis;
    logic [15:0] data;
  } ment_t;

  ment_t       q[$];
  int          m_tail;
  logic        m_cv, m_cwen, m_fl;
  logic [3:0]  m_crd;
  logic [15:0] m_cd;

  function automatic int find(input int t);
    for (int k = 0; k < q.size(); k++) if (q[k].tag == t) return k;
    return -1;
  endfunction

  function automatic logic model_ready();
    if (q.size() >= DEPTH) return 1'b0;
    if (q.size() > 0 && q[0].done && q[0].mis) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_tail = 0; m_cv = 0; m_cwen = 0; m_fl = 0; m_crd = 0; m_cd = 0;
  endtask

  task automatic model_edge(input logic ar);
    logic  fl;
    int    idx;
    ment_t e;
    fl = 1'b0;
    if (q.size() > 0 && q[0].done) begin
      m_cv = 1; m_crd = q[0].rd; m_cwen = q[0].wen; m_cd = q[0].data;
      if (q[0].mis) begin
        fl = 1'b1; q.delete(); m_tail = 0;
      end else begin
        void'(q.pop_front());
      end
    end else begin
      m_cv = 0;
    end
    m_fl = fl;
    if (!fl) begin
      if (cdb_valid) begin
        idx = find(int'(cdb_tag));
        if (idx >= 0) begin
          e = q[idx]; e.done = 1; e.data = cdb_data; e.mis = cdb_mispredict; q[idx] = e;
        end
      end
      if (alloc_valid && ar) begin
        e.tag = m_tail; e.rd = alloc_rd; e.wen = alloc_wen;
        e.done = 0; e.mis = 0; e.data = 0;
        q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  // One clock: check combinational outputs, take the edge, check registers
  task automatic step();
    logic ar;
    int   idx;
    #1;
    ar = model_ready();
    chk("m_alloc_ready", alloc_ready, ar);
    chk("m_alloc_tag", alloc_tag, m_tail);
    idx = find(int'(src_tag));
    if (idx < 0) begin
      chk("m_src_ready", src_ready, 0);
      chk("m_src_data", src_data, 0);
    end else if (cdb_valid && cdb_tag == src_tag) begin
      chk("m_src_ready_byp", src_ready, 1);
      chk("m_src_data_byp", src_data, cdb_data);
    end else begin
      chk("m_src_ready", src_ready, q[idx].done);
      if (q[idx].done) chk("m_src_data", src_data, q[idx].data);
    end
    @(posedge clk1);
    model_edge(ar);
    #1;
    chk("m_commit_valid", commit_valid, m_cv);
    chk("m_commit_rd", commit_rd, m_crd);
    chk("m_commit_wen", commit_wen, m_cwen);
    chk("m_commit_data", commit_data, m_cd);
    chk("m_flush", flush, m_fl);
    chk("m_count", count, q.size());
  endtask

  task automatic drv(input logic av, input logic [3:0] rd, input logic wen,
                     input logic cv, input logic [2:0] ct, input logic [15:0] cd,
                     input logic cm, input logic [2:0] st);
    alloc_valid = av; alloc_rd = rd; alloc_wen = wen;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd; cdb_mispredict = cm; src_tag = st;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk1);
    #1;
    chk("rst_count", count, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_flush", flush, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        av;  logic [3:0]  rd;
    logic        cv;  logic [2:0]  ct;  logic [15:0] cd;  logic [2:0] st;
    logic        ear; logic [2:0]  eat; logic        esr; logic [15:0] esd;
    logic        ecv; logic [3:0]  erd; logic [15:0] ecd; logic [3:0]  ecnt;
  } vec_t;

  vec_t vec[9];

  initial begin
    vec[0] = '{1, 1, 0, 0, 16'h00, 7,  1, 0, 0, 16'h00,  0, 0, 16'h00, 1};
    vec[1] = '{1, 2, 0, 0, 16'h00, 7,  1, 1, 0, 16'h00,  0, 0, 16'h00, 2};
    vec[2] = '{1, 3, 0, 0, 16'h00, 7,  1, 2, 0, 16'h00,  0, 0, 16'h00, 3};
    vec[3] = '{0, 0, 1, 2, 16'h0A, 2,  1, 3, 1, 16'h0A,  0, 0, 16'h00, 3};
    vec[4] = '{0, 0, 1, 0, 16'h0B, 2,  1, 3, 1, 16'h0A,  0, 0, 16'h00, 3};
    vec[5] = '{0, 0, 1, 1, 16'h0C, 0,  1, 3, 1, 16'h0B,  1, 1, 16'h0B, 2};
    vec[6] = '{0, 0, 0, 0, 16'h00, 1,  1, 3, 1, 16'h0C,  1, 2, 16'h0C, 1};
    vec[7] = '{0, 0, 0, 0, 16'h00, 7,  1, 3, 0, 16'h00,  1, 3, 16'h0A, 0};
    vec[8] = '{0, 0, 0, 0, 16'h00, 7,  1, 3, 0, 16'h00,  0, 3, 16'h0A, 0};

    model_reset();
    do_reset();

    // In-order retirement of out-of-order results
    for (int r = 0; r < 9; r++) begin
      drv(vec[r].av, vec[r].rd, 1'b1, vec[r].cv, vec[r].ct, vec[r].cd, 1'b0, vec[r].st);
      #1;
      chk($sformatf("t%0d_alloc_ready", r), alloc_ready, vec[r].ear);
      chk($sformatf("t%0d_alloc_tag", r), alloc_tag, vec[r].eat);
      chk($sformatf("t%0d_src_ready", r), src_ready, vec[r].esr);
      chk($sformatf("t%0d_src_data", r), src_data, vec[r].esd);
      step();
      chk($sformatf("t%0d_commit_valid", r), commit_valid, vec[r].ecv);
      if (vec[r].ecv) begin
        chk($sformatf("t%0d_commit_rd", r), commit_rd, vec[r].erd);
        chk($sformatf("t%0d_commit_data", r), commit_data, vec[r].ecd);
      end
      chk($sformatf("t%0d_count", r), count, vec[r].ecnt);
    end

    // Fill, no allocation while full even with a commit, then wrap to tag 0
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      drv(1, 4'(k), 1, 0, 0, 0, 0, 0);
      step();
    end
    drv(1, 4'hF, 1, 1, 0, 16'h0011, 0, 0);
    #1;
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_count", count, 8);
    step();
    drv(1, 4'hF, 1, 0, 0, 0, 0, 0);
    #1;
    chk("full_commit_alloc_ready", alloc_ready, 0);
    step();
    chk("full_after_commit_count", count, 7);
    chk("full_after_commit_valid", commit_valid, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_alloc_ready", alloc_ready, 1);
    chk("wrap_alloc_tag", alloc_tag, 0);
    step();

    // Same-cycle operand bypass
    do_reset();
    drv(1, 1, 1, 0, 0, 0, 0, 0); step();
    drv(1, 2, 1, 0, 0, 0, 0, 1);
    #1;
    chk("byp_pending_ready", src_ready, 0);
    step();
    drv(0, 0, 0, 1, 1, 16'h0055, 0, 1);
    #1;
    chk("byp_src_ready", src_ready, 1);
    chk("byp_src_data", src_data, 16'h0055);
    step();

    // Mispredicted branch retires and flushes; later CDB to tag 1 is dead
    do_reset();
    drv(1, 0, 0, 0, 0, 0, 0, 0); step();
    drv(1, 5, 1, 0, 0, 0, 0, 0); step();
    drv(1, 6, 1, 0, 0, 0, 0, 0); step();
    drv(1, 7, 1, 1, 0, 16'h0001, 1, 0); step();
    drv(1, 8, 1, 1, 1, 16'h0099, 0, 1);
    #1;
    chk("mis_alloc_ready", alloc_ready, 0);
    step();
    chk("mis_commit_valid", commit_valid, 1);
    chk("mis_commit_wen", commit_wen, 0);
    chk("mis_flush", flush, 1);
    chk("mis_count", count, 0);
    chk("mis_alloc_tag", alloc_tag, 0);
    drv(0, 0, 0, 1, 1, 16'h0077, 0, 1);
    #1;
    chk("mis_dead_src_ready", src_ready, 0);
    chk("mis_dead_src_data", src_data, 0);
    step();
    chk("mis_dead_count", count, 0);
    chk("mis_flush_pulse", flush, 0);

    // Allocate and commit together at count 4, then async reset at count 5
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(1, 4'(k + 8), 1, 0, 0, 0, 0, 0);
      step();
    end
    drv(0, 0, 0, 1, 0, 16'h00AB, 0, 0); step();
    drv(1, 4'hC, 1, 0, 0, 0, 0, 0); step();
    chk("ac_count", count, 4);
    chk("ac_alloc_tag", alloc_tag, 5);
    chk("ac_commit_rd", commit_rd, 8);
    drv(1, 4'hD, 1, 0, 0, 0, 0, 0); step();
    chk("pre_rst_count", count, 5);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_count", count, 0);
    chk("arst_commit_valid", commit_valid, 0);
    chk("arst_commit_rd", commit_rd, 0);
    chk("arst_commit_wen", commit_wen, 0);
    chk("arst_commit_data", commit_data, 0);
    chk("arst_flush", flush, 0);
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
    #1;
    chk("arst_rel_alloc_tag", alloc_tag, 0);
    drv(1, 3, 1, 0, 0, 0, 0, 0); step();
    chk("arst_first_count", count, 1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      drv($urandom_range(0, 9) < 6, 4'($urandom), 1'($urandom),
          $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
          $urandom_range(0, 15) == 0, 3'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised circular reorder buffer for the Tomasulo core. It sits between the issue stage and the register bank. It hands out ROB tags at issue, captures results broadcast on the common data bus (CDB), and forwards ready operands to issue. It retires entries strictly in program order, one per cycle, and flushes all speculative state on a mispredicted branch.

## Interface
- DEPTH, 8: number of entries; power of two, at least 2.
- DATA_W, 16: result data width.
- REG_W, 4: architectural register index width.
- TAG_W, $clog2(DEPTH): ROB tag width.

- clk1 input 1: clock; every register updates on its rising edge.
- rst_n input 1: asynchronous, active-low reset.
- alloc_valid input 1: issue requests a new entry.
- alloc_rd input REG_W: destination register of the new entry.
- alloc_wen input 1: entry writes a register (0 for store/beq/bneq).
- alloc_ready output 1: an entry can be allocated this cycle (combinational).
- alloc_tag output TAG_W: tag granted to the allocation; equals the tail pointer.
- cdb_valid input 1: CDB broadcast present.
- cdb_tag input TAG_W: tag of the broadcast result.
- cdb_data input DATA_W: result value.
- cdb_mispredict input 1: broadcast is a branch that resolved mispredicted.
- src_tag input TAG_W: operand lookup tag from issue.
- src_ready output 1: looked-up entry has a value available (combinational).
- src_data output DATA_W: value for src_tag (combinational).
- commit_valid output 1: registered; one-cycle pulse per retired entry.
- commit_rd output REG_W: registered; rd of the retired entry.
- commit_wen output 1: registered; wen of the retired entry.
- commit_data output DATA_W: registered; data of the retired entry.
- flush output 1: registered; one-cycle pulse when a mispredicted branch retires.
- count output TAG_W+1: number of occupied entries.

## Operation
- Storage per entry: valid, done, mispredict, wen, rd, data. Pointers: head (oldest), tail (next free), count.
- alloc_ready = (count < DEPTH) && !head_flush. head_flush = head entry valid && done && mispredict.
- Allocation occurs when alloc_valid && alloc_ready. The entry at tail gets valid=1, done=0, mispredict=0, rd, wen. Tail increments modulo DEPTH.
- CDB write: if cdb_valid and entry[cdb_tag].valid, that entry gets done=1, data=cdb_data, mispredict=cdb_mispredict. A CDB write to an invalid entry is ignored.
- Commit: if the head entry is valid && done, then at the edge:
  - commit_valid=1 and commit_rd/wen/data are loaded from the head entry.
  - The head entry is cleared and head increments.
  - Otherwise commit_valid=0; the other commit_* outputs hold.
- Mispredict commit: the branch retires normally (commit_valid=1, with its own wen). In the same edge:
  - flush=1.
  - All entries are invalidated.
  - head=tail=count=0.
  - Any allocation or CDB write in that cycle is discarded.
- Operand lookup:
  - If cdb_valid && cdb_tag==src_tag && entry valid: src_ready=1 and src_data=cdb_data (bypass).
  - Otherwise src_ready=entry.valid && entry.done and src_data=entry.data.
  - For an invalid entry: src_ready=0 and src_data=0.
- Count update: +1 on allocate only, -1 on commit only, unchanged when both happen.
- Full-buffer allocation is not bypassed: at count==DEPTH, alloc_ready=0 even when a commit happens that cycle.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - All entries invalid; head=tail=count=0.
  - commit_valid=0, commit_rd=0, commit_wen=0, commit_data=0, flush=0.
  - alloc_ready=1 and alloc_tag=0 once rst_n is high.
- An allocation at edge e is visible (valid, count updated) from e+1.
- A CDB write sampled at edge e sets done after e. The earliest commit edge is e+1, with commit_valid high in the cycle after e+1. CDB-to-commit latency is 2 edges.
- Throughput: at most 1 commit and 1 allocation per cycle.
- Pointers wrap from DEPTH-1 to 0. Tags are reused after retirement.
- The CDB may target the head entry in the same cycle the head is committing a different, already-done state. The CDB write only applies to its own tag.

## Test plan
- Reset, then 3 allocations (rd=1,2,3, wen=1) -> tags 0,1,2 and count=3. CDB tags 2,0,1 with data 0x0A,0x0B,0x0C -> commits in order: rd1=0x0B, rd2=0x0C, rd3=0x0A, one per cycle.
- Fill DEPTH=8 -> alloc_ready=0 at count=8. Commit one entry -> alloc_ready=1 next cycle. The next alloc_tag is 0 (wrap).
- Operand bypass: src_tag=1 with entry 1 pending and a simultaneous CDB tag 1, data 0x55 -> src_ready=1, src_data=0x55 in that same cycle.
- Mispredict: allocate a branch (tag 0, wen=0) plus 2 more entries. CDB tag 0 with mispredict=1 -> commit_valid with commit_wen=0 and flush=1. Next cycle count=0 and alloc_tag=0. A later CDB to tag 1 is ignored.
- Reset asserted with count=5 -> all outputs 0 immediately and count=0. After release, the first allocation gets tag 0.
- Simultaneous allocate and commit at count=4 -> count stays 4; head and tail each advance by 1.
